// File: rtl/interrupt_ctrl_if.sv
// Signal bundle between the interrupt controller and its surroundings:
// device lines, control register file state and the pipeline handshake.
interface interrupt_ctrl_if;
  logic [15:0] irq_in;
  logic [31:0] interrupt_state;
  logic        int_enabled;
  logic        stall;
  logic        irq_ack;
  logic [15:0] interrupts;
  logic        irq_req;
  logic [3:0]  irq_vector;
  logic        busy;

  // Controller side
  modport slave (
    input  irq_in, interrupt_state, int_enabled, stall, irq_ack,
    output interrupts, irq_req, irq_vector, busy
  );

  // Environment side (register file, pipeline, devices)
  modport master (
    output irq_in, interrupt_state, int_enabled, stall, irq_ack,
    input  interrupts, irq_req, irq_vector, busy
  );
endinterface

// File: rtl/interrupt_ctrl.sv
// Interrupt controller: synchronises 16 device lines into ISR set pulses,
// arbitrates the masked pending state and injects one interrupt per
// enable window through a req/ack handshake with the pipeline.
module interrupt_ctrl #(
  parameter logic [15:0] LEVEL_MASK = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  interrupt_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Lowest set index wins; returns 0 for an empty vector (never used then).
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      idx = v[i] ? i[3:0] : idx;
    end
    return idx;
  endfunction

  logic [15:0] s1_r, s2_r, s3_r;
  logic [15:0] interrupts_r;
  state_t      state_r, state_nxt_s;
  logic [3:0]  irq_vector_r, vector_nxt_s;
  logic        irq_req_r;
  logic        busy_r;
  logic        pending_s;
  logic        unused_state_hi_s;

  // The upper half of interrupt_state carries no line information.
  assign unused_state_hi_s = ^bus.interrupt_state[31:16];
  assign pending_s         = (bus.interrupt_state[15:0] != 16'h0000);

  // Two-flop synchroniser plus history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r <= 16'h0000;
      s2_r <= 16'h0000;
      s3_r <= 16'h0000;
    end else begin
      s1_r <= bus.irq_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // ISR set pulses: level lines follow s2, edge lines pulse on a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      interrupts_r <= 16'h0000;
    end else begin
      interrupts_r <= (s2_r & LEVEL_MASK) | (s2_r & ~s3_r & ~LEVEL_MASK);
    end
  end

  // Handshake state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; the vector is latched only when leaving IDLE.
  always_comb begin
    state_nxt_s  = state_r;
    vector_nxt_s = irq_vector_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.int_enabled && pending_s && !bus.stall) begin
          state_nxt_s  = ST_REQ;
          vector_nxt_s = lowest_set(bus.interrupt_state[15:0]);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Acknowledge beats withdraw when both happen together.
        if (bus.irq_ack) begin
          state_nxt_s = ST_DRAIN;
        end else if (!pending_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_DRAIN: begin
        // Wait for the writeback disable so stale state is not re-requested.
        if (!bus.int_enabled) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Registered handshake outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_req_r    <= 1'b0;
      irq_vector_r <= 4'd0;
      busy_r       <= 1'b0;
    end else begin
      irq_req_r    <= (state_nxt_s == ST_REQ);
      irq_vector_r <= vector_nxt_s;
      busy_r       <= (state_nxt_s != ST_IDLE);
    end
  end

  assign bus.interrupts = interrupts_r;
  assign bus.irq_req    = irq_req_r;
  assign bus.irq_vector = irq_vector_r;
  assign bus.busy       = busy_r;

endmodule
